// File: rtl/stream_demux_1_2_if.sv
// rtl/stream_demux_1_2_if.sv - Stream bundle for the 1:2 packet demultiplexer
//
// Purpose: groups the upstream stream (s_*) and both downstream ports (m0_*, m1_*).
// Ports:
//   s_valid/s_ready/s_data/s_last/s_sel : upstream beat with route request
//   m0_valid/m0_ready/m0_data/m0_last   : downstream port 0
//   m1_valid/m1_ready/m1_data/m1_last   : downstream port 1
// Modports:
//   slave  : the demultiplexer (sinks s_*, sources m0_*/m1_*)
//   master : the surroundings (source s_*, sink m0_*/m1_*)
interface stream_demux_1_2_if #(
  parameter int WIDTH = 8
);
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             s_last;
  logic             s_sel;

  logic             m0_valid;
  logic             m0_ready;
  logic [WIDTH-1:0] m0_data;
  logic             m0_last;

  logic             m1_valid;
  logic             m1_ready;
  logic [WIDTH-1:0] m1_data;
  logic             m1_last;

  modport slave (
    input  s_valid, s_data, s_last, s_sel,
    output s_ready,
    output m0_valid, m0_data, m0_last,
    input  m0_ready,
    output m1_valid, m1_data, m1_last,
    input  m1_ready
  );

  modport master (
    output s_valid, s_data, s_last, s_sel,
    input  s_ready,
    input  m0_valid, m0_data, m0_last,
    output m0_ready,
    input  m1_valid, m1_data, m1_last,
    output m1_ready
  );
endinterface

// File: rtl/stream_demux_1_2.sv
// rtl/stream_demux_1_2.sv - Registered 1:2 stream demultiplexer with packet route locking
//
// Purpose: splits one valid/ready stream onto two ports. The route comes from
// s_sel on the first beat of a packet and is held until the s_last beat is
// accepted. Each port has a one-entry register slice (one cycle latency).
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (release synchronised internally)
//   bus   : stream_demux_1_2_if.slave, upstream s_* and ports m0_*/m1_*
module stream_demux_1_2 #(
  parameter int WIDTH = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  stream_demux_1_2_if.slave   bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_t;

  logic [1:0]       r_rst_sync;
  state_t           r_state;
  logic             r_route;

  logic             r_m0_valid;
  logic [WIDTH-1:0] r_m0_data;
  logic             r_m0_last;
  logic             r_m1_valid;
  logic [WIDTH-1:0] r_m1_data;
  logic             r_m1_last;

  logic             w_rst_n;
  logic             w_route;
  logic             w_s_ready;
  logic             w_accept;
  logic             w_load0;
  logic             w_load1;

  // Reset asserts immediately but is released two clock edges later, so the
  // core never sees a reset edge close to a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  // Outside a packet the route follows s_sel directly; inside, the latched one.
  assign w_route   = (r_state == ST_PKT) ? r_route : bus.s_sel;
  // Only the slice on the current route may hold off upstream.
  assign w_s_ready = w_route ? (!r_m1_valid || bus.m1_ready)
                             : (!r_m0_valid || bus.m0_ready);
  assign w_accept  = bus.s_valid && w_s_ready;
  assign w_load0   = w_accept && !w_route;
  assign w_load1   = w_accept &&  w_route;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= ST_IDLE;
      r_route <= 1'b0;
    end else if (w_accept) begin
      unique case (r_state)
        ST_IDLE: begin
          // Single-beat packets never open a packet.
          if (!bus.s_last) begin
            r_route <= bus.s_sel;
            r_state <= ST_PKT;
          end
        end
        ST_PKT: begin
          if (bus.s_last) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Port 0 slice: data/last only change on a load, so they hold while stalled.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_m0_valid <= 1'b0;
      r_m0_data  <= '0;
      r_m0_last  <= 1'b0;
    end else if (w_load0) begin
      r_m0_valid <= 1'b1;
      r_m0_data  <= bus.s_data;
      r_m0_last  <= bus.s_last;
    end else if (bus.m0_ready) begin
      r_m0_valid <= 1'b0;
    end
  end

  // Port 1 slice.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_m1_valid <= 1'b0;
      r_m1_data  <= '0;
      r_m1_last  <= 1'b0;
    end else if (w_load1) begin
      r_m1_valid <= 1'b1;
      r_m1_data  <= bus.s_data;
      r_m1_last  <= bus.s_last;
    end else if (bus.m1_ready) begin
      r_m1_valid <= 1'b0;
    end
  end

  assign bus.s_ready  = w_s_ready;
  assign bus.m0_valid = r_m0_valid;
  assign bus.m0_data  = r_m0_data;
  assign bus.m0_last  = r_m0_last;
  assign bus.m1_valid = r_m1_valid;
  assign bus.m1_data  = r_m1_data;
  assign bus.m1_last  = r_m1_last;

endmodule

// File: tb/tb_stream_demux_1_2.sv
// tb/tb_stream_demux_1_2.sv - Self-checking bench for stream_demux_1_2
module tb_stream_demux_1_2;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  stream_demux_1_2_if #(.WIDTH(W)) bus ();
  stream_demux_1_2 #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: per-port queues of {last, data} awaiting delivery, plus
  // the packet route lock.
  logic [W:0] q0[$];
  logic [W:0] q1[$];
  bit         in_pkt;
  bit         pkt_port;
  bit         hs_up, hs0, hs1, up_port;
  bit         stall0, stall1;
  logic [W:0] held0, held1;
  int         got0;

  typedef struct {
    logic       v;
    logic       sel;
    logic [7:0] d;
    logic       l;
    logic       er;
    logic       e0v;
    logic [7:0] e0d;
    logic       e0l;
    logic       e1v;
    logic [7:0] e1d;
    logic       e1l;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic sel, input logic [W-1:0] d,
                       input logic l, input logic r0, input logic r1);
    bus.s_valid  = v;
    bus.s_sel    = sel;
    bus.s_data   = d;
    bus.s_last   = l;
    bus.m0_ready = r0;
    bus.m1_ready = r1;
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    in_pkt = 0;
    pkt_port = 0;
    stall0 = 0;
    stall1 = 0;
    hs_up = 0;
    hs0 = 0;
    hs1 = 0;
  endtask

  // Called just after inputs change (away from the rising edge).
  task automatic settle_and_check();
    bit exp_port;
    bit exp_sready;
    #1;
    exp_port   = in_pkt ? pkt_port : bus.s_sel;
    exp_sready = exp_port ? (q1.size() == 0 || bus.m1_ready) : (q0.size() == 0 || bus.m0_ready);
    chk("s_ready", 32'(bus.s_ready), 32'(exp_sready));
    chk("m0_valid", 32'(bus.m0_valid), 32'(q0.size() != 0));
    chk("m1_valid", 32'(bus.m1_valid), 32'(q1.size() != 0));
    if (bus.m0_valid && q0.size() > 0)
      chk("m0_beat", 32'({bus.m0_last, bus.m0_data}), 32'(q0[0]));
    if (bus.m1_valid && q1.size() > 0)
      chk("m1_beat", 32'({bus.m1_last, bus.m1_data}), 32'(q1[0]));
    if (stall0) begin
      chk("m0_hold_valid", 32'(bus.m0_valid), 32'd1);
      chk("m0_hold_beat", 32'({bus.m0_last, bus.m0_data}), 32'(held0));
    end
    if (stall1) begin
      chk("m1_hold_valid", 32'(bus.m1_valid), 32'd1);
      chk("m1_hold_beat", 32'({bus.m1_last, bus.m1_data}), 32'(held1));
    end
    hs0    = bus.m0_valid && bus.m0_ready;
    hs1    = bus.m1_valid && bus.m1_ready;
    stall0 = bus.m0_valid && !bus.m0_ready;
    stall1 = bus.m1_valid && !bus.m1_ready;
    held0  = {bus.m0_last, bus.m0_data};
    held1  = {bus.m1_last, bus.m1_data};
    hs_up  = bus.s_valid && bus.s_ready;
    up_port = exp_port;
  endtask

  task automatic advance();
    logic [W:0] beat;
    if (hs0 && q0.size() > 0) begin
      beat = q0.pop_front();
      got0++;
    end
    if (hs1 && q1.size() > 0) beat = q1.pop_front();
    if (hs_up) begin
      beat = {bus.s_last, bus.s_data};
      if (up_port) q1.push_back(beat);
      else q0.push_back(beat);
      if (!in_pkt && !bus.s_last) begin
        in_pkt = 1;
        pkt_port = up_port;
      end else if (in_pkt && bus.s_last) begin
        in_pkt = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, '0, 0, 1, 1);
      settle_and_check();
      advance();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int guard;
    int start0;

    tbl[0] = '{1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 8'h33, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 8'hA0, 1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 8'hA0, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 8'hA1, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 8'hA3, 1'b1, 1'b1, 1'b1, 8'hA2, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA3, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};

    model_reset();
    got0 = 0;
    drive(0, 0, '0, 0, 1, 1);

    // Reset asserted mid-clock.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_m0_valid", 32'(bus.m0_valid), 32'd0);
    chk("rst_m1_valid", 32'(bus.m1_valid), 32'd0);
    chk("rst_s_ready", 32'(bus.s_ready), 32'd1);
    chk("rst_m0_data", 32'({bus.m0_last, bus.m0_data}), 32'd0);
    chk("rst_m1_data", 32'({bus.m1_last, bus.m1_data}), 32'd0);
    @(negedge clk);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(3);

    // Single-beat packets and route lock, table-driven.
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].l, 1, 1);
      settle_and_check();
      chk($sformatf("tbl%0d_s_ready", i), 32'(bus.s_ready), 32'(tbl[i].er));
      chk($sformatf("tbl%0d_m0_valid", i), 32'(bus.m0_valid), 32'(tbl[i].e0v));
      chk($sformatf("tbl%0d_m1_valid", i), 32'(bus.m1_valid), 32'(tbl[i].e1v));
      if (tbl[i].e0v)
        chk($sformatf("tbl%0d_m0_beat", i), 32'({bus.m0_last, bus.m0_data}), 32'({tbl[i].e0l, tbl[i].e0d}));
      if (tbl[i].e1v)
        chk($sformatf("tbl%0d_m1_beat", i), 32'({bus.m1_last, bus.m1_data}), 32'({tbl[i].e1l, tbl[i].e1d}));
      advance();
    end

    // Independent ports: port 1 stalled with 0x55.
    drive(1, 1, 8'h55, 1, 1, 0); settle_and_check(); advance();
    drive(1, 0, 8'h66, 1, 1, 0); settle_and_check();
    chk("indep_s_ready_66", 32'(bus.s_ready), 32'd1); advance();
    drive(1, 0, 8'h77, 1, 1, 0); settle_and_check();
    chk("indep_s_ready_77", 32'(bus.s_ready), 32'd1);
    chk("indep_m0_66", 32'({bus.m0_valid, bus.m0_data}), 32'({1'b1, 8'h66})); advance();
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 8'h88, 1, 1, 0); settle_and_check();
      chk("indep_blocked", 32'(bus.s_ready), 32'd0);
      chk("indep_m1_55_held", 32'({bus.m1_valid, bus.m1_data}), 32'({1'b1, 8'h55}));
      advance();
    end
    drive(1, 1, 8'h88, 1, 1, 1); settle_and_check();
    chk("indep_unblocked", 32'(bus.s_ready), 32'd1); advance();
    drive(0, 0, '0, 0, 1, 1); settle_and_check();
    chk("indep_m1_88", 32'({bus.m1_valid, bus.m1_data}), 32'({1'b1, 8'h88})); advance();
    idle_cycles(2);

    // Backpressure during a 6-beat packet on port 0.
    start0 = got0;
    for (int i = 0; i < 6; i++) begin
      guard = 0;
      while (1) begin
        drive(1, (i == 0) ? 1'b0 : 1'($urandom_range(0, 1)), W'(8'hC0 + i), (i == 5),
              1'($urandom_range(0, 1)), 1);
        settle_and_check();
        if (hs_up) break;
        advance();
        guard++;
        if (guard > 50) begin
          chk("bp_accept_timeout", 32'(guard), 32'd0);
          break;
        end
      end
      advance();
    end
    guard = 0;
    while ((q0.size() != 0) && (guard < 60)) begin
      drive(0, 0, '0, 0, (guard > 40) ? 1'b1 : 1'($urandom_range(0, 1)), 1);
      settle_and_check();
      advance();
      guard++;
    end
    chk("bp_beats_delivered", 32'(got0 - start0), 32'd6);
    idle_cycles(2);

    // Reset in the middle of a 4-beat sel=1 packet.
    drive(1, 1, 8'hB0, 0, 1, 1); settle_and_check(); advance();
    drive(1, 1, 8'hB1, 0, 1, 1); settle_and_check(); advance();
    drive(0, 0, '0, 0, 1, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_m1_valid", 32'(bus.m1_valid), 32'd0);
    chk("mid_rst_m0_valid", 32'(bus.m0_valid), 32'd0);
    chk("mid_rst_s_ready", 32'(bus.s_ready), 32'd1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(3);
    drive(1, 0, 8'h99, 1, 1, 1); settle_and_check(); advance();
    drive(0, 0, '0, 0, 1, 1); settle_and_check();
    chk("mid_rst_m0_99", 32'({bus.m0_valid, bus.m0_last, bus.m0_data}), 32'({2'b11, 8'h99}));
    chk("mid_rst_m1_quiet", 32'(bus.m1_valid), 32'd0);
    advance();
    idle_cycles(3);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), W'($urandom),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 3) != 0));
      settle_and_check();
      advance();
    end
    idle_cycles(4);
    chk("final_q0_empty", 32'(q0.size()), 32'd0);
    chk("final_q1_empty", 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
